fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the MIPS pipeline. Holds the fetch PC, issues requests to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions in a prefetch queue. Presents instructions to decode via a valid/ready handshake. Applies branch/jump redirects (pcSrc, pc_branched) by flushing the queue and killing in-flight reads.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage: PC step
//             derivation, default widths, default reset PC and the prefetch
//             queue entry layout.
//  Ports    : none (package)
//  Options  : FETCH_PERF_EN (consumed by fetch_unit, not by this package)
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned c_DEF_PC_W     = 32;
    localparam int unsigned c_DEF_INSTR_W  = 32;
    localparam logic [31:0] c_DEF_RESET_PC = 32'h0000_0000;

    // The fetch PC advances by one instruction, expressed in bytes.
    function automatic int unsigned pc_step(input int unsigned instr_w);
        return instr_w / 8;
    endfunction

    // Queue entry at the default widths; fetch_unit declares the same
    // layout locally with its parameterised widths.
    typedef struct packed {
        logic [c_DEF_INSTR_W-1:0] instr;
        logic [c_DEF_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Parameterised synchronous FIFO used as the prefetch queue.
//             Flush has priority over push and pop; the head entry is
//             presented combinationally on o_rdata.
//  Ports    : clk, rst_n (async, active-low)
//             i_push/i_wdata  - write an entry
//             i_pop           - drop the head entry
//             i_flush         - empty the queue
//             o_rdata         - head entry
//             o_full/o_empty/o_count - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push & ~i_flush & ~o_full;
    assign w_pop  = i_pop  & ~i_flush & ~o_empty;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Holds the fetch PC, issues reads to a
//             synchronous instruction memory (1-cycle latency), buffers the
//             returned words in a prefetch queue and hands them to decode
//             over a valid/ready handshake. A redirect (pcSrc) reloads the
//             PC, flushes the queue and discards any read in flight.
//  Ports    : clk, rst_n (async, active-low)
//             pcSrc, pc_branched          - redirect request / target
//             imem_req, imem_addr         - memory read request
//             imem_rdata                  - memory read data (next cycle)
//             instruction, pc_out         - head-of-queue instruction / PC
//             instr_valid, instr_ready    - decode handshake
//             perf_fetched, perf_flushes  - only with FETCH_PERF_EN
//  Options  : FETCH_PERF_EN - adds wrapping counters of accepted
//             instructions and redirect edges.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      PC_W        = c_DEF_PC_W,
    parameter int unsigned      INSTR_W     = c_DEF_INSTR_W,
    parameter int unsigned      QUEUE_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_PC    = PC_W'(c_DEF_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pcSrc,
    input  logic [PC_W-1:0]     pc_branched,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instruction,
    output logic [PC_W-1:0]     pc_out,
    output logic                instr_valid,
    input  logic                instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_flushes
`endif
);

    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(pc_step(INSTR_W));
    localparam logic [PC_W-1:0] c_PC_MASK = ~(c_PC_STEP - 1'b1);
    localparam int unsigned     c_CNT_W   = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_in_flight;
    logic [PC_W-1:0]    r_inflight_pc;

    entry_t             w_wdata;
    entry_t             w_head;
    logic               w_q_full;
    logic               w_q_empty;
    logic [c_CNT_W-1:0] w_q_count;
    logic [c_CNT_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // A slot is reserved for every outstanding read so a response can
    // always be written without checking for space.
    assign w_occupancy = w_q_count + c_CNT_W'(r_in_flight);
    assign w_issue     = ~pcSrc & ~w_q_full
                       & (w_occupancy < c_CNT_W'(QUEUE_DEPTH));

    // Gating with rst_n keeps the request low for the whole reset window
    // while letting the first read go out as soon as reset is released.
    assign imem_req  = rst_n & w_issue;
    assign imem_addr = r_fetch_pc;

    // A redirect on the response edge kills that response.
    assign w_push = r_in_flight & ~pcSrc;
    assign w_pop  = instr_valid & instr_ready & ~pcSrc;

    assign w_wdata.instr = imem_rdata;
    assign w_wdata.pc    = r_inflight_pc;

    assign instr_valid = ~w_q_empty;
    assign instruction = w_head.instr;
    assign pc_out      = w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_in_flight   <= 1'b0;
            r_inflight_pc <= '0;
        end else if (pcSrc) begin
            r_fetch_pc  <= pc_branched & c_PC_MASK;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_PC_STEP;
            end
        end
    end

    fetch_queue #(
        .WIDTH (INSTR_W + PC_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (pcSrc),
        .o_rdata (w_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (w_pop) begin
                perf_fetched <= perf_fetched + 1'b1;
            end
            if (pcSrc) begin
                perf_flushes <= perf_flushes + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit. A behavioural
//             instruction memory returns mem[addr/4] = (addr/4)*0x11 one
//             cycle after each request.
//  Options  : FETCH_PERF_EN - also checks the performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcSrc;
    logic [31:0] pc_branched;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
    logic [31:0] r_fetched_snap;
    logic [31:0] r_flushes_snap;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_req;

    fetch_unit u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcSrc       (pcSrc),
        .pc_branched (pc_branched),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushes (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) * 32'h11;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        #1;
        chk({tag, " valid"}, 64'(instr_valid), 64'(1'b1));
        chk({tag, " pc"},    64'(pc_out),      64'(pc));
        chk({tag, " instr"}, 64'(instruction), 64'(mem_word(pc)));
    endtask

    // Called at a negedge with rst_n low: release reset with decode ready
    // and check the start-up latency and the first four instructions.
    task automatic startup_stream(input string tag);
        instr_ready = 1'b1;
        pcSrc       = 1'b0;
        rst_n       = 1'b1;
        #1;
        chk({tag, " first req"},  64'(imem_req),  64'(1'b1));
        chk({tag, " first addr"}, 64'(imem_addr), 64'h0);
        @(negedge clk);
        #1;
        chk({tag, " valid after 1 edge"}, 64'(instr_valid), 64'(1'b0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_head($sformatf("%s head%0d", tag, k), 32'(4 * k));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pcSrc       = 1'b0;
        instr_ready = 1'b0;
        pc_branched = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset valid", 64'(instr_valid), 64'(1'b0));
        chk("reset req",   64'(imem_req),    64'(1'b0));
        chk("reset instr", 64'(instruction), 64'h0);
        chk("reset pc",    64'(pc_out),      64'h0);

        // Start-up stream
        startup_stream("boot");

        // Back-pressure: queue fills with exactly QUEUE_DEPTH requests
        rst_n = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        rst_n       = 1'b1;
        n_req       = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) n_req++;
            @(negedge clk);
        end
        #1;
        chk("full req count", 64'(n_req),    64'd4);
        chk("full req low",   64'(imem_req), 64'(1'b0));
        expect_head("full head", 32'h0);
        instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            expect_head($sformatf("drain%0d", k), 32'(4 * k));
        end

        // Redirect to 8 while a read is in flight
        pcSrc       = 1'b1;
        pc_branched = 32'h8;
        #1;
        chk("redir no req", 64'(imem_req), 64'(1'b0));
        @(negedge clk);
        pcSrc = 1'b0;
        #1;
        chk("redir flushed",  64'(instr_valid), 64'(1'b0));
        chk("redir tgt req",  64'(imem_req),    64'(1'b1));
        chk("redir tgt addr", 64'(imem_addr),   64'h8);
        @(negedge clk);
        #1;
        chk("redir edge1 valid", 64'(instr_valid), 64'(1'b0));
        @(negedge clk);
        expect_head("redir tgt", 32'h8);
        @(negedge clk);
        expect_head("redir next", 32'hC);

        // Unaligned target is aligned down
        pcSrc       = 1'b1;
        pc_branched = 32'h23;
        @(negedge clk);
        pcSrc = 1'b0;
        #1;
        chk("unal flushed", 64'(instr_valid), 64'(1'b0));
        @(negedge clk);
        @(negedge clk);
        expect_head("unal tgt", 32'h20);

        // Redirect in the same cycle as a pop
`ifdef FETCH_PERF_EN
        r_fetched_snap = perf_fetched;
        r_flushes_snap = perf_flushes;
`endif
        pcSrc       = 1'b1;
        pc_branched = 32'h40;
        @(negedge clk);
        pcSrc = 1'b0;
        #1;
        chk("pop+redir flushed", 64'(instr_valid), 64'(1'b0));
`ifdef FETCH_PERF_EN
        chk("perf fetched held", 64'(perf_fetched), 64'(r_fetched_snap));
        chk("perf flushes inc",  64'(perf_flushes), 64'(r_flushes_snap + 32'd1));
`endif
        @(negedge clk);
        @(negedge clk);
        expect_head("pop+redir tgt", 32'h40);
        @(negedge clk);
        expect_head("pop+redir next", 32'h44);
`ifdef FETCH_PERF_EN
        chk("perf fetched pop", 64'(perf_fetched), 64'(r_fetched_snap + 32'd1));
`endif

        // Back-to-back redirects: the last one wins
        pcSrc       = 1'b1;
        pc_branched = 32'h100;
        @(negedge clk);
        pc_branched = 32'h200;
        #1;
        chk("b2b no req", 64'(imem_req), 64'(1'b0));
        @(negedge clk);
        pcSrc = 1'b0;
        #1;
        chk("b2b addr", 64'(imem_addr), 64'h200);
        @(negedge clk);
        @(negedge clk);
        expect_head("b2b tgt", 32'h200);

        // Address wrap
        pcSrc       = 1'b1;
        pc_branched = 32'hFFFF_FFF8;
        @(negedge clk);
        pcSrc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_head("wrap0", 32'hFFFF_FFF8);
        @(negedge clk);
        expect_head("wrap1", 32'hFFFF_FFFC);
        @(negedge clk);
        expect_head("wrap2", 32'h0000_0000);

        // Mid-stream reset
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 64'(instr_valid), 64'(1'b0));
        chk("midrst req",   64'(imem_req),    64'(1'b0));
        chk("midrst pc",    64'(pc_out),      64'h0);
        @(negedge clk);
        startup_stream("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
